// File: rtl/tblink_rpc_ep_neto_arb_pkg.sv
// Shared definitions for the endpoint network-output arbiter.
// Holds FSM state encodings, header field mask and source indices.
// Pure declarations; no timing or flow-control behaviour of its own.
package tblink_rpc_ep_neto_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CNT  = 2'd2,
    ST_DATA = 2'd3
  } arb_state_e;

  // Destination field of the header byte; bit 7 is reserved.
  localparam logic [6:0] HDR_ADDR_MASK = 7'h7F;

  localparam logic SRC_PT  = 1'b0;
  localparam logic SRC_TIP = 1'b1;

  // Count byte N encodes N+1 payload bytes; widen first so N=255 gives 256.
  function automatic logic [8:0] payload_len(input logic [7:0] cnt);
    return {1'b0, cnt} + 9'd1;
  endfunction

endpackage

// File: rtl/tblink_rpc_out_reg.sv
// Single-entry 8-bit ready/valid register stage.
// Latency 1 cycle from input accept to output valid.
// Accepts when empty or draining this cycle, so full rate under load+unload.
module tblink_rpc_out_reg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_dat_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_dat_o
);

  logic       valid_q, valid_d;
  logic [7:0] dat_q, dat_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_dat_o   = dat_q;

  // Load on input handshake, otherwise clear when the consumer takes the byte.
  always_comb begin
    valid_d = valid_q;
    dat_d   = dat_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      dat_d   = in_dat_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Storage register; data stays stable while the output is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      valid_q <= valid_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: rtl/tblink_rpc_ep_neto_arb.sv
// Packet-granular round-robin arbiter of pass-through and TIP bytes onto neto.
// Latency 1 cycle source-accept to neto_valid; one idle bubble per packet.
// Source ready follows the output register; halt blocks only new grants.
module tblink_rpc_ep_neto_arb
  import tblink_rpc_ep_neto_arb_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic       hreq_i,
  output logic       hreq_o,
  input  logic       pt_valid,
  output logic       pt_ready,
  input  logic [7:0] pt_dat,
  input  logic       tip_valid,
  output logic       tip_ready,
  input  logic [7:0] tip_dat,
  output logic       neto_valid,
  input  logic       neto_ready,
  output logic [7:0] neto_dat
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [8:0] rem_q, rem_d;

  logic       busy;
  logic       src_valid;
  logic [7:0] src_dat;
  logic       reg_in_ready;
  logic       src_acc;

  assign busy      = (state_q != ST_IDLE);
  assign src_valid = (grant_q == SRC_TIP) ? tip_valid : pt_valid;
  assign src_dat   = (grant_q == SRC_TIP) ? tip_dat   : pt_dat;
  assign src_acc   = busy & src_valid & reg_in_ready;

  assign pt_ready  = busy & (grant_q == SRC_PT)  & reg_in_ready;
  assign tip_ready = busy & (grant_q == SRC_TIP) & reg_in_ready;

  // Quiesced means idle with nothing left in the output register.
  assign hreq_o = hreq_i & ~reset & (state_q == ST_IDLE) & ~neto_valid;

  tblink_rpc_out_reg u_out_reg (
    .clk_i       (uclock),
    .rst_i       (reset),
    .in_valid_i  (busy & src_valid),
    .in_ready_o  (reg_in_ready),
    .in_dat_i    (src_dat),
    .out_valid_o (neto_valid),
    .out_ready_i (neto_ready),
    .out_dat_o   (neto_dat)
  );

  // Packet framing walk and grant selection.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (!hreq_i && (pt_valid || tip_valid)) begin
          // Contention goes to whichever source did not have the last packet.
          grant_d = (pt_valid && tip_valid) ? ~last_q : tip_valid;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (src_acc) state_d = ST_CNT;
      end
      ST_CNT: begin
        if (src_acc) begin
          rem_d   = payload_len(src_dat);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (src_acc) begin
          rem_d = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state; the last-grant pointer starts opposite RR_INIT so RR_INIT wins first.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= SRC_PT;
      last_q  <= ~RR_INIT;
      rem_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_tblink_rpc_ep_neto_arb.sv
module tb_tblink_rpc_ep_neto_arb;

  localparam logic RR_INIT = 1'b0;

  logic       uclock = 1'b0;
  logic       reset = 1'b1;
  logic       hreq_i = 1'b1;
  logic       hreq_o;
  logic       pt_valid = 1'b0, tip_valid = 1'b0, neto_ready = 1'b0;
  logic       pt_ready, tip_ready, neto_valid;
  logic [7:0] pt_dat = 8'h00, tip_dat = 8'h00, neto_dat;

  tblink_rpc_ep_neto_arb #(.RR_INIT(RR_INIT)) dut (
    .uclock(uclock), .reset(reset), .hreq_i(hreq_i), .hreq_o(hreq_o),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_dat(pt_dat),
    .tip_valid(tip_valid), .tip_ready(tip_ready), .tip_dat(tip_dat),
    .neto_valid(neto_valid), .neto_ready(neto_ready), .neto_dat(neto_dat)
  );

  always #5 uclock = ~uclock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source packet stores: flat byte memory plus per-packet lengths.
  logic [7:0] mem [2][8192];
  int head[2], tail[2];
  int plen[2][256];
  int phead[2], ptail[2], psent[2];
  int pushed;

  int vprob = 100;   // percent chance a source with data drives valid
  int nmode = 0;     // 0: neto_ready high, 1: toggle, 2: random
  bit hmode = 0;     // random halt requests

  // Behavioural model: packet-in-flight view plus a one-byte output slot.
  bit         m_busy, m_src, m_last, m_occ;
  logic [7:0] m_dat;
  int         m_idx, m_total;

  logic [7:0] log_b[$];
  int         log_c[$];
  int         cyc, first_vld;
  bit         tip_seen;

  function automatic bit has(input int s);
    return head[s] < tail[s];
  endfunction

  function automatic logic [31:0] get(input int i);
    return (i < log_b.size()) ? {24'h0, log_b[i]} : 32'hEEE;
  endfunction

  task automatic push_pkt(input int s, input logic [7:0] hdr, input logic [7:0] n, input logic [7:0] base);
    mem[s][tail[s]++] = hdr;
    mem[s][tail[s]++] = n;
    for (int i = 0; i <= int'(n); i++) mem[s][tail[s]++] = base + 8'(i);
    plen[s][ptail[s]++] = int'(n) + 3;
    pushed += int'(n) + 3;
  endtask

  task automatic pop(input int s);
    head[s]++;
    psent[s]++;
    if (psent[s] == plen[s][phead[s]]) begin
      phead[s]++;
      psent[s] = 0;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_occ = 0; m_src = 0; m_last = ~RR_INIT;
    m_dat = 8'h00; m_idx = 0; m_total = 1000;
  endtask

  task automatic drive();
    pt_valid  = has(0) && ($urandom % 100 < vprob);
    pt_dat    = has(0) ? mem[0][head[0]] : 8'h00;
    tip_valid = has(1) && ($urandom % 100 < vprob);
    tip_dat   = has(1) ? mem[1][head[1]] : 8'h00;
    case (nmode)
      0: neto_ready = 1'b1;
      1: neto_ready = ~neto_ready;
      default: neto_ready = 1'($urandom % 2);
    endcase
    if (hmode) hreq_i = ($urandom % 100 < 8);
  endtask

  // One cycle: compare at the falling edge, advance model, then drive after the rising edge.
  task automatic step();
    bit space, acc, src_v;
    logic [7:0] src_d;
    @(negedge uclock);
    cyc++;
    if (!reset) begin
      space = !m_occ || neto_ready;
      check("pt_ready", pt_ready, m_busy && !m_src && space);
      check("tip_ready", tip_ready, m_busy && m_src && space);
      check("neto_valid", neto_valid, m_occ);
      if (m_occ) check("neto_dat", neto_dat, m_dat);
      check("hreq_o", hreq_o, hreq_i && !m_busy && !m_occ);
      if (neto_valid && neto_ready) begin
        log_b.push_back(neto_dat);
        log_c.push_back(cyc);
      end
      if (neto_valid && first_vld < 0) first_vld = cyc;
      if (tip_ready) tip_seen = 1;
      src_v = m_src ? tip_valid : pt_valid;
      src_d = m_src ? tip_dat : pt_dat;
      acc = m_busy && src_v && space;
      if (m_occ && neto_ready) m_occ = 0;
      if (acc) begin
        m_occ = 1;
        m_dat = src_d;
        if (m_idx == 1) m_total = int'(src_d) + 3;
        m_idx++;
        if (m_idx == m_total) begin
          m_busy = 0;
          m_last = m_src;
        end
      end else if (!m_busy && !hreq_i && (pt_valid || tip_valid)) begin
        m_busy  = 1;
        m_src   = (pt_valid && tip_valid) ? ~m_last : tip_valid;
        m_idx   = 0;
        m_total = 1000;
      end
      if (pt_valid && pt_ready) pop(0);
      if (tip_valid && tip_ready) pop(1);
    end
    @(posedge uclock);
    #1;
    drive();
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((has(0) || has(1) || m_busy || m_occ) && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", (n < budget), 1);
    repeat (3) step();
  endtask

  // Called just after a rising edge: asynchronous reset, flush sources and model.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_neto_valid", neto_valid, 0);
    check("rst_pt_ready", pt_ready, 0);
    model_reset();
    for (int s = 0; s < 2; s++) begin
      head[s] = tail[s]; phead[s] = ptail[s]; psent[s] = 0;
    end
    pt_valid = 0; tip_valid = 0;
    @(posedge uclock); @(posedge uclock); #1;
    reset = 1'b0;
    log_b.delete(); log_c.delete();
    first_vld = -1; tip_seen = 0; cyc = 0; pushed = 0;
    drive();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    for (int s = 0; s < 2; s++) begin
      head[s] = 0; tail[s] = 0; phead[s] = 0; ptail[s] = 0; psent[s] = 0;
    end
    model_reset();
    first_vld = -1; cyc = 0; pushed = 0; tip_seen = 0;

    // Reset values, with halt requested during reset.
    #2;
    check("reset_neto_valid", neto_valid, 0);
    check("reset_neto_dat", neto_dat, 8'h00);
    check("reset_pt_ready", pt_ready, 0);
    check("reset_tip_ready", tip_ready, 0);
    check("reset_hreq_o", hreq_o, 0);
    @(posedge uclock); @(posedge uclock); #1;
    reset = 1'b0;
    #1;
    check("hreq_o_after_release", hreq_o, 1);
    hreq_i = 1'b0;

    // Single pass-through packet.
    push_pkt(0, 8'h05, 8'h02, 8'hA1);
    drive();
    c0 = cyc + 1;
    run_drain(50);
    check("t1_count", log_b.size(), 5);
    check("t1_b0", get(0), 8'h05);
    check("t1_b1", get(1), 8'h02);
    check("t1_b2", get(2), 8'hA1);
    check("t1_b4", get(4), 8'hA3);
    check("t1_latency", first_vld - c0, 2);
    check("t1_tip_ready_never", tip_seen, 0);

    // Both sources continuously valid with one-byte payloads: strict alternation.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 8'h11, 8'h00, 8'hB0 + 8'(k));
      push_pkt(1, 8'h22, 8'h00, 8'hC0 + 8'(k));
    end
    drive();
    run_drain(100);
    check("t2_count", log_b.size(), 18);
    check("t2_pkt0", get(0), 8'h11);
    check("t2_pkt1", get(3), 8'h22);
    check("t2_pkt2", get(6), 8'h11);
    check("t2_pkt3", get(9), 8'h22);
    check("t2_pkt_spacing", (log_c.size() > 3) ? log_c[3] - log_c[0] : -1, 4);
    check("t2_back_to_back", (log_c.size() > 2) ? log_c[2] - log_c[0] : -1, 2);

    // Maximum-length TIP packet.
    do_reset();
    push_pkt(1, 8'h7F, 8'hFF, 8'h00);
    drive();
    run_drain(400);
    check("t3_count", log_b.size(), 258);
    check("t3_cnt_byte", get(1), 8'hFF);
    check("t3_first_payload", get(2), 8'h00);
    check("t3_last_payload", get(257), 8'hFF);

    // neto_ready toggling.
    do_reset();
    nmode = 1;
    push_pkt(0, 8'h21, 8'h04, 8'h10);
    push_pkt(1, 8'h22, 8'h07, 8'h40);
    push_pkt(0, 8'h23, 8'h02, 8'h60);
    drive();
    run_drain(200);
    check("t4_count", log_b.size(), 22);
    check("t4_first_hdr", get(0), 8'h21);
    nmode = 0;

    // Halt raised mid-packet with a second packet pending.
    do_reset();
    push_pkt(0, 8'h44, 8'h03, 8'h90);
    push_pkt(0, 8'h45, 8'h00, 8'h9A);
    drive();
    repeat (3) step();
    hreq_i = 1'b1;
    repeat (15) step();
    check("t5_first_pkt_done", log_b.size(), 6);
    check("t5_hreq_o_high", hreq_o, 1);
    hreq_i = 1'b0;
    #1;
    check("t5_hreq_o_fall", hreq_o, 0);
    run_drain(50);
    check("t5_count", log_b.size(), 9);
    check("t5_second_hdr", get(6), 8'h45);

    // Reset while in the payload with a byte held in the output register.
    do_reset();
    push_pkt(0, 8'h55, 8'h05, 8'hD0);
    drive();
    repeat (6) step();
    check("t6_mid_packet_valid", neto_valid, 1);
    do_reset();
    push_pkt(1, 8'h33, 8'h01, 8'h70);
    drive();
    run_drain(50);
    check("t6_count", log_b.size(), 4);
    check("t6_hdr", get(0), 8'h33);
    check("t6_cnt", get(1), 8'h01);
    check("t6_last", get(3), 8'h71);

    // Randomized traffic, valid gaps, backpressure and halt pulses.
    do_reset();
    vprob = 70; nmode = 2; hmode = 1;
    for (int k = 0; k < 40; k++) begin
      push_pkt(0, 8'($urandom), 8'($urandom_range(0, 12)), 8'($urandom));
      push_pkt(1, 8'($urandom), 8'($urandom_range(0, 12)), 8'($urandom));
    end
    drive();
    run_drain(20000);
    hmode = 0; hreq_i = 1'b0;
    check("rand_total_bytes", log_b.size(), pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
